sysctl_timer_bank: RTL and testbench

//  Parametrised bank of NTIMERS general-purpose timers on the CSR bus, next generation of the

---
 rtl/sysctl_timer_bank.sv | 189 ++++++++++++++++++
 tb/tb_sysctl_timer_bank.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sysctl_timer_bank.sv
// NTIMERS-way CSR timer bank with sticky masked pending bits and one aggregated level IRQ.
// Optional shared prescaler enabled by defining SYSCTL_TIMER_BANK_PRESCALER_EN.
module sysctl_timer_bank_lane #(
  parameter int width = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             tick_i,
  input  logic             wr_ctrl_i,
  input  logic             wr_cmp_i,
  input  logic             wr_cnt_i,
  input  logic             clr_i,
  input  logic [width-1:0] wdata_i,
  input  logic [1:0]       wctrl_i,
  output logic [width-1:0] cnt_o,
  output logic [width-1:0] cmp_o,
  output logic             en_o,
  output logic             ar_o,
  output logic             pend_o
);
  logic [width-1:0] cnt_q, cnt_d, cmp_q, cmp_d;
  logic             en_q, en_d, ar_q, ar_d, pend_q, hit;

  always_comb begin
    cnt_d = cnt_q;
    cmp_d = cmp_q;
    en_d  = en_q;
    ar_d  = ar_q;
    hit   = 1'b0;
    if (tick_i && en_q) begin
      if (cnt_q != cmp_q) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        hit = 1'b1;
        if (ar_q) cnt_d = '0;
        else      en_d  = 1'b0;
      end
    end
    // CSR writes override whatever the counter logic decided this cycle
    if (wr_ctrl_i) {ar_d, en_d} = wctrl_i;
    if (wr_cmp_i)  cmp_d = wdata_i;
    if (wr_cnt_i)  cnt_d = wdata_i;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q  <= '0;
      cmp_q  <= '1;
      en_q   <= 1'b0;
      ar_q   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cmp_q  <= cmp_d;
      en_q   <= en_d;
      ar_q   <= ar_d;
      pend_q <= hit | (pend_q & ~clr_i);
    end
  end

  assign cnt_o  = cnt_q;
  assign cmp_o  = cmp_q;
  assign en_o   = en_q;
  assign ar_o   = ar_q;
  assign pend_o = pend_q;
endmodule

module sysctl_timer_bank #(
  parameter logic [3:0]  csr_addr = 4'h0,
  parameter int          ntimers  = 4,
  parameter int          width    = 32,
  parameter logic [31:0] clk_freq = 32'd50000000
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [13:0]        csr_a,
  input  logic               csr_we,
  input  logic [31:0]        csr_di,
  output logic [31:0]        csr_do,
  output logic               irq,
  output logic [ntimers-1:0] timer_irq
);
  logic                          sel, wr, tick;
  logic [5:0]                    ra;
  logic [2:0]                    tidx;
  logic [1:0]                    tsub;
  logic [ntimers-1:0]            mask_q, pend, en, ar;
  logic [ntimers-1:0][width-1:0] cnt, cmp;
  logic [31:0]                   csr_do_q, rd_d, prescale_rd;
  logic                          irq_q;
  logic [ntimers-1:0]            timer_irq_q;
  logic                          unused_a;

  assign sel      = (csr_a[13:10] == csr_addr);
  assign wr       = sel & csr_we;
  assign ra       = csr_a[5:0];
  assign tidx     = csr_a[4:2];
  assign tsub     = csr_a[1:0];
  assign unused_a = ^csr_a[9:6];

`ifdef SYSCTL_TIMER_BANK_PRESCALER_EN
  logic [15:0] prescale_q, pcnt_q;

  assign tick        = (pcnt_q == 16'h0);
  assign prescale_rd = {16'h0, prescale_q};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      prescale_q <= '0;
      pcnt_q     <= '0;
    end else if (wr && ra == 6'h02) begin
      prescale_q <= csr_di[15:0];
      pcnt_q     <= csr_di[15:0];
    end else if (tick) begin
      pcnt_q <= prescale_q;
    end else begin
      pcnt_q <= pcnt_q - 16'h1;
    end
  end
`else
  assign tick        = 1'b1;
  assign prescale_rd = 32'h0;
`endif

  for (genvar g = 0; g < ntimers; g++) begin : g_lane
    logic wr_t;
    assign wr_t = wr && ra[5] && (tidx == 3'(g));
    sysctl_timer_bank_lane #(.width(width)) u_lane (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .tick_i   (tick),
      .wr_ctrl_i(wr_t && tsub == 2'd0),
      .wr_cmp_i (wr_t && tsub == 2'd1),
      .wr_cnt_i (wr_t && tsub == 2'd2),
      .clr_i    (wr && ra == 6'h00 && csr_di[g]),
      .wdata_i  (csr_di[width-1:0]),
      .wctrl_i  (csr_di[1:0]),
      .cnt_o    (cnt[g]),
      .cmp_o    (cmp[g]),
      .en_o     (en[g]),
      .ar_o     (ar[g]),
      .pend_o   (pend[g])
    );
  end

  always_comb begin
    rd_d = 32'h0;
    if (sel) begin
      if (!ra[5]) begin
        case (ra)
          6'h00:   rd_d = 32'(pend);
          6'h01:   rd_d = 32'(mask_q);
          6'h02:   rd_d = prescale_rd;
          6'h03:   rd_d = clk_freq;
          default: rd_d = 32'h0;
        endcase
      end else begin
        for (int i = 0; i < ntimers; i++) begin
          if (tidx == 3'(i)) begin
            case (tsub)
              2'd0:    rd_d = {30'h0, ar[i], en[i]};
              2'd1:    rd_d = 32'(cmp[i]);
              2'd2:    rd_d = 32'(cnt[i]);
              default: rd_d = 32'h0;
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mask_q      <= '0;
      csr_do_q    <= '0;
      irq_q       <= 1'b0;
      timer_irq_q <= '0;
    end else begin
      if (wr && ra == 6'h01) mask_q <= csr_di[ntimers-1:0];
      csr_do_q    <= rd_d;
      irq_q       <= |(pend & mask_q);
      timer_irq_q <= pend & mask_q;
    end
  end

  assign csr_do    = csr_do_q;
  assign irq       = irq_q;
  assign timer_irq = timer_irq_q;
endmodule

// File: tb/tb_sysctl_timer_bank.sv
// Scoreboard bench: a 32-bit/4-timer bank at bank 0 and an 8-bit/3-timer bank at bank 1 share the bus.
module tb_sysctl_timer_bank;
  logic        sys_clk = 1'b0, sys_rst = 1'b1, csr_we = 1'b0;
  logic [13:0] csr_a = '0;
  logic [31:0] csr_di = '0, do32, do8;
  logic        irq32, irq8;
  logic [3:0]  tirq32;
  logic [2:0]  tirq8;

  sysctl_timer_bank u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di),
    .csr_do(do32), .irq(irq32), .timer_irq(tirq32));

  sysctl_timer_bank #(.csr_addr(4'h1), .ntimers(3), .width(8)) u_dut8 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di),
    .csr_do(do8), .irq(irq8), .timer_irq(tirq8));

  always #5 sys_clk = ~sys_clk;

  int          n_tests = 0, n_fail = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic        rd_now = 1'b0, mon_b;
  logic [31:0] mon_e;
  string       mon_t;

  localparam logic [13:0] PEND = 14'h000, MASK = 14'h001, PRESC = 14'h002, CFREQ = 14'h003;
  localparam logic [13:0] PEND8 = 14'h400, MASK8 = 14'h401;

  function automatic logic [13:0] tad(input logic [3:0] bank, input logic [2:0] n, input logic [1:0] sub);
    return {bank, 4'h0, 1'b1, n, sub};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic we, input logic [13:0] a, input logic [31:0] d,
                     input logic rd, input logic [31:0] e, input string tag);
    @(negedge sys_clk);
    csr_we = we; csr_a = a; csr_di = d; rd_now = rd;
    if (rd) begin
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    cyc(1'b1, a, d, 1'b0, 32'h0, "");
  endtask

  task automatic rd(input logic [13:0] a, input logic [31:0] e, input string tag);
    cyc(1'b0, a, 32'h0, 1'b1, e, tag);
  endtask

  task automatic idle();
    cyc(1'b0, 14'h0, 32'h0, 1'b0, 32'h0, "");
  endtask

  // csr_do is registered: the value for the address presented before an edge is checked just after it
  always @(posedge sys_clk) begin
    if (rd_now) begin
      mon_b = (csr_a[13:10] == 4'h1);
      #1;
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'h1, 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = tag_q.pop_front();
        chk(mon_t, mon_b ? do8 : do32, mon_e);
        chk({mon_t, "_nosel"}, mon_b ? do32 : do8, 32'h0);
      end
    end
  end

  initial begin
    repeat (3) idle();
    sys_rst = 1'b0;
    chk("rst_irq", irq32, 0);
    chk("rst_tirq", tirq32, 0);
    rd(PEND, 0, "rst_pend");
    rd(MASK, 0, "rst_mask");
    rd(PRESC, 0, "rst_presc");
    rd(CFREQ, 32'd50000000, "clk_freq");
    rd(tad(0, 0, 0), 0, "rst_ctrl");
    rd(tad(0, 0, 1), 32'hFFFF_FFFF, "rst_cmp");
    rd(tad(0, 0, 2), 0, "rst_cnt");
    rd(tad(0, 0, 3), 0, "rsvd");
    rd(tad(1, 2, 1), 32'hFF, "rst_cmp8");
    rd(14'h004, 0, "unmapped");

    // T0 auto-reload, compare 3
    wr(tad(0, 0, 1), 3);
    wr(MASK, 1);
    wr(tad(0, 0, 0), 3);
    rd(tad(0, 0, 2), 0, "t0_cnt0");
    rd(tad(0, 0, 2), 1, "t0_cnt1");
    rd(tad(0, 0, 2), 2, "t0_cnt2");
    rd(tad(0, 0, 2), 3, "t0_cnt3");
    rd(tad(0, 0, 2), 0, "t0_cnt_wrap");
    chk("t0_irq_lag", irq32, 0);
    wr(PEND, 1);
    chk("t0_irq_hi", irq32, 1);
    chk("t0_tirq_hi", tirq32, 4'h1);
    rd(PEND, 0, "t0_w1c");
    chk("t0_irq_w1c_lag", irq32, 1);
    rd(PEND, 0, "t0_pend_pre");
    chk("t0_irq_dropped", irq32, 0);
    rd(PEND, 1, "t0_pend_period");
    idle();
    chk("t0_irq_again", irq32, 1);
    idle();
    wr(PEND, 1);                      // W1C collides with a match
    rd(PEND, 1, "set_beats_clr");
    idle();
    idle();
    wr(tad(0, 0, 2), 2);              // counter write on a match cycle
    rd(tad(0, 0, 2), 2, "cntwr_wins");
    rd(tad(0, 0, 2), 3, "cntwr_next");
    rd(tad(0, 0, 2), 0, "cntwr_wrap");
    wr(MASK, 0);
    idle();
    idle();
    chk("mask_irq", irq32, 0);
    chk("mask_tirq", tirq32, 0);
    rd(PEND, 1, "mask_keeps_pend");
    wr(tad(0, 0, 0), 0);
    wr(PEND, 1);
    rd(PEND, 0, "t0_stopped_clr");
    wr(tad(0, 0, 2), 7);
    wr(tad(0, 0, 0), 2);
    rd(tad(0, 0, 2), 7, "ctrl_keeps_cnt");
    rd(tad(0, 0, 0), 2, "ctrl_rd");

    // T1 one-shot, compare 5
    wr(tad(0, 1, 1), 5);
    wr(tad(0, 1, 0), 1);
    repeat (5) idle();
    rd(PEND, 0, "t1_pend_early");
    rd(PEND, 2, "t1_pend");
    rd(tad(0, 1, 0), 0, "t1_ctrl_off");
    rd(tad(0, 1, 2), 5, "t1_cnt_hold");
    rd(tad(0, 1, 2), 5, "t1_cnt_hold2");
    chk("t1_masked_irq", irq32, 0);
    wr(PEND, 2);
    rd(PEND, 0, "t1_clr");
    cyc(1'b1, MASK, 3, 1'b1, 0, "rd_prewrite");
    rd(MASK, 3, "mask_rd");
    wr(MASK, 0);

    // 8-bit bank: wrap through all-ones
    wr(tad(1, 2, 2), 32'h1FE);
    wr(tad(1, 2, 1), 1);
    wr(tad(1, 2, 0), 1);
    rd(tad(1, 2, 2), 32'hFE, "w8_fe");
    rd(tad(1, 2, 2), 32'hFF, "w8_ff");
    rd(tad(1, 2, 2), 32'h00, "w8_00");
    rd(tad(1, 2, 2), 32'h01, "w8_01");
    rd(PEND8, 4, "w8_pend");
    rd(tad(1, 2, 2), 32'h01, "w8_hold");
    wr(tad(1, 3, 1), 7);
    rd(tad(1, 3, 1), 0, "idx_oob8");
    wr(tad(0, 5, 1), 7);
    rd(tad(0, 5, 1), 0, "idx_oob32");
    wr(MASK8, 32'hFF);
    rd(MASK8, 7, "mask8_trunc");
    idle();
    chk("irq8", irq8, 1);
    chk("tirq8", tirq8, 3'h4);

`ifdef SYSCTL_TIMER_BANK_PRESCALER_EN
    wr(PRESC, 9);
    rd(PRESC, 9, "presc_rd");
    wr(tad(0, 0, 1), 2);
    wr(tad(0, 0, 2), 0);
    wr(PEND, 1);
    wr(tad(0, 0, 0), 3);
    repeat (24) idle();
    rd(PEND, 0, "ps_pend_pre");
    cyc(1'b1, PEND, 1, 1'b1, 1, "ps_pend_30");
    repeat (28) idle();
    rd(PEND, 0, "ps_pend_pre2");
    rd(PEND, 1, "ps_pend_60");
`else
    wr(PRESC, 9);
    rd(PRESC, 0, "presc_off_rd");
    wr(tad(0, 0, 1), 2);
    wr(tad(0, 0, 2), 0);
    wr(tad(0, 0, 0), 3);
    rd(PEND, 0, "np_pend_a");
    rd(PEND, 0, "np_pend_b");
    rd(PEND, 0, "np_pend_c");
    cyc(1'b1, PEND, 1, 1'b1, 1, "np_pend_3");
    rd(PEND, 0, "np_pend_d");
    rd(PEND, 0, "np_pend_e");
    rd(PEND, 1, "np_pend_6");
`endif

    // reset while T0 is counting with an IRQ up
    wr(MASK, 1);
    idle();
    idle();
    chk("irq_prerst", irq32, 1);
    sys_rst = 1'b1;
    idle();
    sys_rst = 1'b0;
    chk("rst_mid_irq", irq32, 0);
    rd(tad(0, 0, 0), 0, "rst_mid_ctrl");
    rd(tad(0, 0, 2), 0, "rst_mid_cnt");
    rd(MASK, 0, "rst_mid_mask");
    rd(PEND, 0, "rst_mid_pend");
    repeat (4) idle();
    chk("rst_mid_noirq", irq32, 0);

    idle();
    idle();
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
